grid_io_array_cfg: RTL and testbench

GRID_IO_ARRAY_CFG -- requirements
Module: grid_io_array_cfg

---
 rtl/grid_io_array_cfg.sv | 120 ++++++++++++
 tb/tb_grid_io_array_cfg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/grid_io_array_cfg.sv
// Configurable pad channel array: a scan-chain frame is shifted in, then committed to a shadow register that steers each pad.
// Pad outputs settle one cycle after commit; no backpressure. `define IO_PARITY_EN to append an even-parity bit to the frame.
module grid_io_array_cfg #(
  parameter int NUM_CH = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              IO_ISOL_N,
  input  logic [NUM_CH-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_CH-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_CH-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_CH-1:0] outpad,
  output logic [NUM_CH-1:0] inpad_upper,
  output logic [NUM_CH-1:0] inpad_lower,
  input  logic              ccff_head,
  input  logic              ccff_shift_en,
  input  logic              ccff_commit,
  output logic              ccff_tail,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int ACT_W = 2 * NUM_CH;
`ifdef IO_PARITY_EN
  localparam int CFG_W = ACT_W + 1;
`else
  localparam int CFG_W = ACT_W;
`endif
  localparam int CNT_W = $clog2(CFG_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_LOADING,
    FR_FULL,
    FR_OVER
  } frame_t;

  logic [CFG_W-1:0] sr;
  logic [ACT_W-1:0] act;
  logic [CNT_W-1:0] cnt;
  frame_t           frame;
  logic             parity_ok;
  logic             commit_ok;
  logic             pads_live;
  logic [NUM_CH-1:0] inpad_dat;

  always_comb begin
    frame = FR_LOADING;
    if (cnt == '0)
      frame = FR_IDLE;
    else if (cnt == CNT_FULL)
      frame = FR_FULL;
    else if (cnt > CNT_FULL)
      frame = FR_OVER;
  end

`ifdef IO_PARITY_EN
  assign parity_ok = ~(^sr);
`else
  assign parity_ok = 1'b1;
`endif

  assign commit_ok = (frame == FR_FULL) && parity_ok;
  assign ccff_tail = sr[CFG_W-1];

  // A commit coinciding with a shift is a framing error: the new bit starts a fresh frame.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      sr        <= '0;
      act       <= '0;
      cnt       <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (ccff_shift_en)
        sr <= {sr[CFG_W-2:0], ccff_head};

      if (ccff_shift_en && ccff_commit) begin
        cfg_err <= 1'b1;
        cnt     <= CNT_ONE;
      end else if (ccff_commit) begin
        if (commit_ok) begin
          act       <= sr[ACT_W-1:0];
          cfg_valid <= 1'b1;
          cfg_err   <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
        cnt <= '0;
      end else if (ccff_shift_en && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign pads_live = IO_ISOL_N && cfg_valid;

  // Isolated or unconfigured channels park as inputs with every data path quiet.
  always_comb begin
    gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = '1;
    gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = '0;
    inpad_dat                        = '0;
    if (pads_live) begin
      for (int c = 0; c < NUM_CH; c++) begin
        gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[c] = ~act[2*c];
        if (act[2*c])
          gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[c] = outpad[c] ^ act[2*c+1];
        else
          inpad_dat[c] = gfpga_pad_EMBEDDED_IO_HD_SOC_IN[c] ^ act[2*c+1];
      end
    end
  end

  assign inpad_upper = inpad_dat;
  assign inpad_lower = inpad_dat;

endmodule

// File: tb/tb_grid_io_array_cfg.sv
// Directed bench for grid_io_array_cfg at NUM_CH=4; frames follow the parity setting of the build.
module tb_grid_io_array_cfg;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       IO_ISOL_N;
  logic [3:0] pad_in;
  logic [3:0] pad_out;
  logic [3:0] pad_dir;
  logic [3:0] outpad;
  logic [3:0] inpad_upper;
  logic [3:0] inpad_lower;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       ccff_commit;
  logic       ccff_tail;
  logic       cfg_valid;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  grid_io_array_cfg #(.NUM_CH(4)) dut (
    .prog_clk                         (prog_clk),
    .pReset                           (pReset),
    .IO_ISOL_N                        (IO_ISOL_N),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir),
    .outpad                           (outpad),
    .inpad_upper                      (inpad_upper),
    .inpad_lower                      (inpad_lower),
    .ccff_head                        (ccff_head),
    .ccff_shift_en                    (ccff_shift_en),
    .ccff_commit                      (ccff_commit),
    .ccff_tail                        (ccff_tail),
    .cfg_valid                        (cfg_valid),
    .cfg_err                          (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    ccff_head     = b;
    ccff_shift_en = 1'b1;
    tick();
    ccff_shift_en = 1'b0;
  endtask

  task automatic commit();
    ccff_commit = 1'b1;
    tick();
    ccff_commit = 1'b0;
  endtask

  // Whole frame MSB-first; with parity the even-parity bit leads.
  task automatic load_frame(input logic [7:0] v);
`ifdef IO_PARITY_EN
    shift_bit(^v);
`endif
    for (int i = 7; i >= 0; i--) shift_bit(v[i]);
  endtask

  function automatic logic exp_tail(input logic [7:0] v);
`ifdef IO_PARITY_EN
    return ^v;
`else
    return v[7];
`endif
  endfunction

  task automatic chk_pads(input string tag, input logic [3:0] dir, input logic [3:0] o,
                          input logic [3:0] ip);
    chk({tag, "_dir"}, 32'(pad_dir), 32'(dir));
    chk({tag, "_out"}, 32'(pad_out), 32'(o));
    chk({tag, "_inu"}, 32'(inpad_upper), 32'(ip));
    chk({tag, "_inl"}, 32'(inpad_lower), 32'(ip));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pReset        = 1'b1;
    IO_ISOL_N     = 1'b1;
    pad_in        = 4'b1010;
    outpad        = 4'b1011;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_commit   = 1'b0;
    #12;
    chk("rst_valid", 32'(cfg_valid), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_tail", 32'(ccff_tail), 0);
    chk_pads("rst", 4'b1111, 4'b0000, 4'b0000);
    pReset = 1'b0;
    tick();

    // 0x55: every channel drives, no inversion
    load_frame(8'h55);
    chk("pre_commit_valid", 32'(cfg_valid), 0);
    chk_pads("pre_commit", 4'b1111, 4'b0000, 4'b0000);
    chk("tail55", 32'(ccff_tail), 32'(exp_tail(8'h55)));
    commit();
    chk("c55_valid", 32'(cfg_valid), 1);
    chk("c55_err", 32'(cfg_err), 0);
    chk_pads("c55", 4'b0000, 4'b1011, 4'b0000);
    outpad = 4'b0110;
    #1;
    chk("c55_out2", 32'(pad_out), 32'(4'b0110));

    // isolation forces safe state and releases without reload
    IO_ISOL_N = 1'b0;
    #1;
    chk_pads("iso", 4'b1111, 4'b0000, 4'b0000);
    tick();
    IO_ISOL_N = 1'b1;
    #1;
    chk_pads("uniso", 4'b0000, 4'b0110, 4'b0000);

    // 0xAA: every channel receives, inverted
    load_frame(8'hAA);
    chk("tailAA", 32'(ccff_tail), 32'(exp_tail(8'hAA)));
    commit();
    pad_in = 4'b1010;
    #1;
    chk_pads("cAA", 4'b1111, 4'b0000, 4'b0101);

    // short frame rejected; active config survives
    for (int i = 0; i < 5; i++) shift_bit(1'b0);
    commit();
    chk("short_err", 32'(cfg_err), 1);
    chk("short_valid", 32'(cfg_valid), 1);
    chk_pads("short", 4'b1111, 4'b0000, 4'b0101);
    load_frame(8'h55);
    chk("sticky_err", 32'(cfg_err), 1);
    commit();
    chk("reload_err", 32'(cfg_err), 0);
    chk_pads("reload", 4'b0000, 4'b0110, 4'b0000);

    // one bit too many rejected
    load_frame(8'hAA);
    shift_bit(1'b0);
    commit();
    chk("over_err", 32'(cfg_err), 1);
    chk_pads("over", 4'b0000, 4'b0110, 4'b0000);

    // shift+commit together: error, and the shifted bit opens a new frame
    ccff_commit = 1'b1;
`ifdef IO_PARITY_EN
    shift_bit(1'b0);
    ccff_commit = 1'b0;
    chk("sc_err", 32'(cfg_err), 1);
    for (int i = 7; i >= 0; i--) shift_bit(i[0] ? 1'b1 : 1'b0);
`else
    shift_bit(1'b1);
    ccff_commit = 1'b0;
    chk("sc_err", 32'(cfg_err), 1);
    for (int i = 6; i >= 0; i--) shift_bit(i[0] ? 1'b1 : 1'b0);
`endif
    chk_pads("sc", 4'b0000, 4'b0110, 4'b0000);
    commit();
    chk("sc_next_err", 32'(cfg_err), 0);
    chk_pads("sc_next", 4'b1111, 4'b0000, 4'b0101);

    // mixed per-channel config 0x93
    load_frame(8'h93);
    commit();
    outpad = 4'b1111;
    pad_in = 4'b1111;
    #1;
    chk_pads("mix1", 4'b1010, 4'b0100, 4'b0010);
    outpad = 4'b0000;
    pad_in = 4'b0000;
    #1;
    chk_pads("mix0", 4'b1010, 4'b0001, 4'b1000);

`ifdef IO_PARITY_EN
    // wrong parity rejected, active config kept
    shift_bit(1'b1);
    for (int i = 7; i >= 0; i--) shift_bit(i[0] ? 1'b0 : 1'b1);
    commit();
    chk("par_err", 32'(cfg_err), 1);
    chk("par_valid", 32'(cfg_valid), 1);
    chk_pads("par", 4'b1010, 4'b0001, 4'b1000);
`endif

    // reset mid-frame discards partial bits
    for (int i = 0; i < 3; i++) shift_bit(1'b1);
    pReset = 1'b1;
    #2;
    chk("mrst_valid", 32'(cfg_valid), 0);
    chk("mrst_tail", 32'(ccff_tail), 0);
    chk_pads("mrst", 4'b1111, 4'b0000, 4'b0000);
    pReset = 1'b0;
    outpad = 4'b1001;
    load_frame(8'h55);
    commit();
    chk("post_rst_valid", 32'(cfg_valid), 1);
    chk("post_rst_err", 32'(cfg_err), 0);
    chk_pads("post_rst", 4'b0000, 4'b1001, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
